// File: rtl/irq_ctrl_if.sv
// Wishbone classic bus bundle, 32-bit data.
// Master drives the request side, the slave returns data and ack.
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0]  sel;
  logic        ack;

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  dat_r, ack
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output dat_r, ack
  );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronised sources, level/edge pending,
// mask, software force and lowest-index-first vector to the CPU.
module irq_ctrl #(
  parameter int NSRC        = 8,
  parameter int VECW        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  if_wb.slave             bus,
  input  logic [NSRC-1:0] src_i,
  input  logic            enabled,
  output logic [VECW-1:0] inter,
  output logic            irq_any
);

  localparam logic [2:0] A_PEND  = 3'd0;
  localparam logic [2:0] A_MASK  = 3'd1;
  localparam logic [2:0] A_MODE  = 3'd2;
  localparam logic [2:0] A_ACT   = 3'd3;
  localparam logic [2:0] A_FORCE = 3'd4;

  logic [SYNC_STAGES-1:0][NSRC-1:0] sync_q;
  logic [NSRC-1:0] synced;
  logic [NSRC-1:0] prev_q;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic [NSRC-1:0] set_e, clr, frc, to_edge;
  logic [NSRC-1:0] req, wdat;
  logic [VECW-1:0] vec, vec_q, inter_q;
  logic            irq_any_q;
  logic            ack_q, ack_d;
  logic            acc, wr;
  logic [2:0]      addr;
  logic [31:0]     rdata;
  logic            unused_bits;

  assign synced = sync_q[SYNC_STAGES-1];
  assign acc    = bus.cyc & bus.stb;
  assign ack_d  = acc & ~ack_q;
  assign wr     = ack_q & acc & bus.we;
  assign addr   = bus.adr[4:2];
  assign wdat   = bus.dat_w[NSRC-1:0];
  assign req    = pend_q & mask_q;

  assign unused_bits = ^{bus.sel, bus.adr[31:5],
                         bus.adr[1:0], bus.dat_w[31:NSRC]};

  // Source synchroniser chain plus the edge-detect history flop.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= src_i;
      for (int s = 1; s < SYNC_STAGES; s++)
        sync_q[s] <= sync_q[s-1];
      prev_q <= synced;
    end
  end

  // Register writes and per-source pending next state; set beats clear.
  always_comb begin
    set_e   = synced & ~prev_q;
    clr     = '0;
    frc     = '0;
    to_edge = '0;
    mask_d  = mask_q;
    mode_d  = mode_q;
    pend_d  = '0;
    if (wr) begin
      case (addr)
        A_PEND:  clr = wdat & mode_q;
        A_MASK:  mask_d = wdat;
        A_MODE: begin
          mode_d  = wdat;
          to_edge = wdat & ~mode_q;
        end
        A_FORCE: frc = wdat & mode_q;
        default: ;
      endcase
    end
    for (int k = 0; k < NSRC; k++) begin
      if (to_edge[k])
        pend_d[k] = 1'b0;
      else if (mode_q[k])
        pend_d[k] = (pend_q[k] & ~clr[k]) | set_e[k] | frc[k];
      else
        pend_d[k] = synced[k];
    end
  end

  // Lowest requesting index wins; vector is index+1, 0 when idle.
  always_comb begin
    vec = '0;
    for (int k = NSRC - 1; k >= 0; k--)
      if (req[k]) vec = VECW'(k + 1);
  end

  // Control/status state and the registered CPU-facing outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pend_q    <= '0;
      mask_q    <= '0;
      mode_q    <= '0;
      vec_q     <= '0;
      inter_q   <= '0;
      irq_any_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      vec_q     <= vec;
      inter_q   <= enabled ? vec : '0;
      irq_any_q <= |req;
      ack_q     <= ack_d;
    end
  end

  // Read mux; data is presented only while ack is high.
  always_comb begin
    rdata = '0;
    case (addr)
      A_PEND: rdata[NSRC-1:0] = pend_q;
      A_MASK: rdata[NSRC-1:0] = mask_q;
      A_MODE: rdata[NSRC-1:0] = mode_q;
      A_ACT: begin
        rdata[31]       = irq_any_q;
        rdata[VECW-1:0] = vec_q;
      end
      default: ;
    endcase
  end

  assign bus.dat_r = ack_q ? rdata : '0;
  assign bus.ack   = ack_q;
  assign inter     = inter_q;
  assign irq_any   = irq_any_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: reset, level, edge, priority,
// set/clear collision, gating, force and mid-access reset.
module tb_irq_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] src = '0;
  logic       en = 1'b0;
  logic [3:0] inter;
  logic       irq_any;
  int         errors = 0;
  int         checks = 0;
  logic [31:0] rd;

  if_wb bus ();

  irq_ctrl #(.NSRC(8), .VECW(4), .SYNC_STAGES(2)) dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .bus     (bus),
    .src_i   (src),
    .enabled (en),
    .inter   (inter),
    .irq_any (irq_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [2:0] a,
                         input logic [31:0] d,
                         output logic [31:0] q);
    logic got;
    got = 1'b0;
    q   = '0;
    tick(1);
    bus.cyc   = 1'b1;
    bus.stb   = 1'b1;
    bus.we    = w;
    bus.adr   = {27'd0, a, 2'b00};
    bus.dat_w = d;
    for (int i = 0; i < 8 && !got; i++) begin
      tick(1);
      if (bus.ack === 1'b1) begin
        got = 1'b1;
        q   = bus.dat_r;
      end
    end
    chk("ack", {31'd0, got}, 32'd1);
    tick(1);
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    bus.we  = 1'b0;
  endtask

  task automatic wb_wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, a, d, dummy);
  endtask

  task automatic wb_rd(input logic [2:0] a, output logic [31:0] q);
    wb_xfer(1'b0, a, 32'd0, q);
  endtask

  initial begin
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    bus.adr = '0; bus.dat_w = '0; bus.sel = 4'hF;

    // reset with all sources high
    src = 8'hFF;
    tick(3);
    chk("rst_inter", {28'd0, inter}, 32'd0);
    chk("rst_irq_any", {31'd0, irq_any}, 32'd0);
    rst_n = 1'b1;
    wb_rd(3'd0, rd); chk("rst_pend", rd, 32'h0);
    wb_rd(3'd1, rd); chk("rst_mask", rd, 32'h0);
    wb_rd(3'd2, rd); chk("rst_mode", rd, 32'h0);
    tick(10);
    wb_rd(3'd0, rd); chk("lvl_pend_ff", rd, 32'hFF);
    chk("mask0_inter", {28'd0, inter}, 32'd0);

    // level source latency
    src = 8'h00;
    tick(5);
    wb_wr(3'd1, 32'h08);
    en = 1'b1;
    tick(2);
    src[3] = 1'b1;
    tick(3);
    chk("lvl_rise_early", {28'd0, inter}, 32'd0);
    tick(1);
    chk("lvl_rise", {28'd0, inter}, 32'd4);
    src[3] = 1'b0;
    tick(3);
    chk("lvl_fall_early", {28'd0, inter}, 32'd4);
    tick(1);
    chk("lvl_fall", {28'd0, inter}, 32'd0);
    src[3] = 1'b1;
    tick(6);
    wb_wr(3'd0, 32'h08);
    wb_rd(3'd0, rd); chk("lvl_w1c_noeff", rd, 32'h08);

    // level->edge with held source gives no pending
    wb_wr(3'd2, 32'hFF);
    wb_wr(3'd1, 32'hFF);
    tick(4);
    wb_rd(3'd0, rd); chk("to_edge_held", rd, 32'h0);
    src[3] = 1'b0;
    tick(4);

    // edge sticky and priority
    src[5] = 1'b1;
    tick(2);
    src[5] = 1'b0;
    tick(6);
    chk("edge5_inter", {28'd0, inter}, 32'd6);
    wb_rd(3'd0, rd); chk("edge5_pend", rd, 32'h20);
    tick(10);
    chk("edge5_sticky", {28'd0, inter}, 32'd6);
    src[1] = 1'b1;
    tick(2);
    src[1] = 1'b0;
    tick(6);
    chk("edge1_prio", {28'd0, inter}, 32'd2);
    wb_wr(3'd0, 32'h02);
    chk("w1c2_same", {28'd0, inter}, 32'd2);
    tick(1);
    chk("w1c2_next", {28'd0, inter}, 32'd6);
    wb_wr(3'd0, 32'h20);
    tick(1);
    chk("w1c20", {28'd0, inter}, 32'd0);

    // set and clear of bit 0 on the same edge
    src[0] = 1'b1;
    wb_wr(3'd0, 32'h01);
    wb_rd(3'd0, rd); chk("set_wins", rd, 32'h01);
    src[0] = 1'b0;
    tick(4);
    wb_wr(3'd0, 32'h01);
    wb_rd(3'd0, rd); chk("bit0_cleared", rd, 32'h0);

    // gating and force
    en = 1'b0;
    wb_wr(3'd4, 32'h04);
    tick(1);
    chk("gate_inter", {28'd0, inter}, 32'd0);
    chk("gate_any", {31'd0, irq_any}, 32'd1);
    wb_rd(3'd3, rd); chk("active", rd, 32'h80000003);
    wb_rd(3'd4, rd); chk("force_rd0", rd, 32'h0);
    wb_rd(3'd6, rd); chk("unused_rd0", rd, 32'h0);
    en = 1'b1;
    tick(1);
    chk("ungate_inter", {28'd0, inter}, 32'd3);
    wb_wr(3'd2, 32'h7F);
    wb_wr(3'd4, 32'h80);
    tick(2);
    wb_rd(3'd0, rd); chk("force_lvl", rd, 32'h04);
    chk("force_lvl_int", {28'd0, inter}, 32'd3);

    // asynchronous reset in the middle of an access
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0;
    bus.adr = 32'h0;
    tick(1);
    chk("mid_ack_up", {31'd0, bus.ack}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_inter", {28'd0, inter}, 32'd0);
    chk("arst_ack", {31'd0, bus.ack}, 32'd0);
    chk("arst_any", {31'd0, irq_any}, 32'd0);
    tick(2);
    bus.cyc = 1'b0; bus.stb = 1'b0;
    rst_n = 1'b1;
    tick(2);
    chk("post_noack", {31'd0, bus.ack}, 32'd0);
    wb_rd(3'd0, rd); chk("post_pend", rd, 32'h0);
    wb_rd(3'd1, rd); chk("post_mask", rd, 32'h0);

    // level->edge with held-high source after reset
    src[4] = 1'b1;
    tick(6);
    wb_wr(3'd2, 32'hFF);
    tick(6);
    wb_rd(3'd0, rd); chk("post_to_edge", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
